// File: rtl/pic16f84_hex_pkg.sv
// rtl/pic16f84_hex_pkg.sv - shared types and constants for the Intel HEX program loader
package pic16f84_hex_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_ADDR,
    S_TYPE,
    S_DATA,
    S_CSUM,
    S_WRITE
  } state_t;

  localparam logic [7:0] REC_DATA = 8'h00;
  localparam logic [7:0] REC_EOF  = 8'h01;
  localparam logic [7:0] REC_ELA  = 8'h04;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CHAR = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;
  localparam logic [1:0] ERR_REC  = 2'd3;

endpackage

// File: rtl/pic16f84_hex_nibble.sv
// rtl/pic16f84_hex_nibble.sv - combinational ASCII hex digit to nibble decoder
module pic16f84_hex_nibble (
  input  logic [7:0] ch,
  output logic [3:0] nib,
  output logic       hex_ok
);

  always_comb begin
    nib    = 4'd0;
    hex_ok = 1'b0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      nib    = ch[3:0];
      hex_ok = 1'b1;
    end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so adding 9 gives 10..15
      nib    = ch[3:0] + 4'd9;
      hex_ok = 1'b1;
    end
  end

endmodule

// File: rtl/pic16f84_hex_loader.sv
// rtl/pic16f84_hex_loader.sv - streaming Intel HEX decoder writing verified words to program memory
module pic16f84_hex_loader
  import pic16f84_hex_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int WORD_W    = 14,
  parameter int MAX_BYTES = 16
) (
  input  logic              clk,
  input  logic              mclr_n,
  input  logic [7:0]        char_in,
  input  logic              char_valid,
  output logic              char_ready,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [WORD_W-1:0] pm_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int BUF_D = MAX_BYTES / 2;
  localparam int IDX_W = $clog2(BUF_D);

  state_t            state;
  logic [3:0]        nib, hi_nib;
  logic              hex_ok, have_hi;
  logic [7:0]        byte_val, sum, sum_next, len, rtype, byte_cnt, lo_byte, wr_idx, out_idx;
  logic [14:0]       addr_w;
  logic [15:0]       segment, seg_new, wa;
  logic              in_range, fire, buf_we, bad_rec;
  logic [WORD_W-1:0] wbuf [BUF_D];
  logic [WORD_W-1:0] out_word;

  pic16f84_hex_nibble u_nibble (.ch(char_in), .nib(nib), .hex_ok(hex_ok));

  assign fire     = char_valid && char_ready;
  assign byte_val = {hi_nib, nib};
  assign sum_next = sum + byte_val;
  assign bad_rec  = (len > 8'(MAX_BYTES)) || ((byte_val == REC_DATA) && len[0]) ||
                    !((byte_val == REC_DATA) || (byte_val == REC_EOF) || (byte_val == REC_ELA));

  // Word 0 is presented on the checksum edge itself, later words from WRITE
  assign out_idx  = (state == S_WRITE) ? wr_idx : 8'd0;
  assign wa       = {1'b0, addr_w} + {8'd0, out_idx};
  assign in_range = (segment == 16'd0) && (wa[15:ADDR_W] == '0);
  assign out_word = wbuf[out_idx[IDX_W-1:0]];
  assign buf_we   = fire && hex_ok && have_hi && (state == S_DATA) &&
                    (rtype == REC_DATA) && byte_cnt[0];

  always_ff @(posedge clk) begin
    if (buf_we) wbuf[byte_cnt[IDX_W:1]] <= {byte_val[5:0], lo_byte};
  end

  always_ff @(posedge clk or negedge mclr_n) begin
    if (!mclr_n) begin
      state      <= S_IDLE;
      char_ready <= 1'b1;
      pm_we      <= 1'b0;
      pm_addr    <= '0;
      pm_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
      hi_nib     <= 4'd0;
      have_hi    <= 1'b0;
      sum        <= 8'd0;
      len        <= 8'd0;
      rtype      <= 8'd0;
      byte_cnt   <= 8'd0;
      lo_byte    <= 8'd0;
      wr_idx     <= 8'd0;
      addr_w     <= 15'd0;
      segment    <= 16'd0;
      seg_new    <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (fire && !done && char_in == 8'h3A) begin
            state    <= S_LEN;
            busy     <= 1'b1;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            sum      <= 8'd0;
            have_hi  <= 1'b0;
            byte_cnt <= 8'd0;
            seg_new  <= 16'd0;
          end
        end
        S_WRITE: begin
          if (wr_idx == {1'b0, len[7:1]}) begin
            pm_we      <= 1'b0;
            state      <= S_IDLE;
            char_ready <= 1'b1;
            busy       <= 1'b0;
          end else begin
            pm_we   <= in_range;
            pm_addr <= wa[ADDR_W-1:0];
            pm_data <= out_word;
            wr_idx  <= wr_idx + 8'd1;
          end
        end
        default: begin
          if (fire) begin
            if (!hex_ok) begin
              err      <= 1'b1;
              err_code <= ERR_CHAR;
              state    <= S_IDLE;
              busy     <= 1'b0;
            end else if (!have_hi) begin
              hi_nib  <= nib;
              have_hi <= 1'b1;
            end else begin
              have_hi <= 1'b0;
              sum     <= sum_next;
              case (state)
                S_LEN: begin
                  len      <= byte_val;
                  byte_cnt <= 8'd0;
                  state    <= S_ADDR;
                end
                S_ADDR: begin
                  if (byte_cnt == 8'd0) begin
                    addr_w[14:7] <= byte_val;
                    byte_cnt     <= 8'd1;
                  end else begin
                    addr_w[6:0] <= byte_val[7:1];
                    state       <= S_TYPE;
                  end
                end
                S_TYPE: begin
                  rtype    <= byte_val;
                  byte_cnt <= 8'd0;
                  if (bad_rec) begin
                    err      <= 1'b1;
                    err_code <= ERR_REC;
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                  end else begin
                    state <= (len == 8'd0) ? S_CSUM : S_DATA;
                  end
                end
                S_DATA: begin
                  if (!byte_cnt[0]) lo_byte <= byte_val;
                  if (byte_cnt == 8'd0) seg_new[15:8] <= byte_val;
                  if (byte_cnt == 8'd1) seg_new[7:0] <= byte_val;
                  byte_cnt <= byte_cnt + 8'd1;
                  if (byte_cnt + 8'd1 == len) state <= S_CSUM;
                end
                S_CSUM: begin
                  if (sum_next != 8'd0) begin
                    err      <= 1'b1;
                    err_code <= ERR_CSUM;
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                  end else if (rtype == REC_DATA && len != 8'd0) begin
                    state      <= S_WRITE;
                    char_ready <= 1'b0;
                    pm_we      <= in_range;
                    pm_addr    <= wa[ADDR_W-1:0];
                    pm_data    <= out_word;
                    wr_idx     <= 8'd1;
                  end else begin
                    if (rtype == REC_EOF) done <= 1'b1;
                    if (rtype == REC_ELA) segment <= seg_new;
                    state <= S_IDLE;
                    busy  <= 1'b0;
                  end
                end
                default: state <= S_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule
